// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state, opcode and PC-mode encodings for the sequencer
package pc_seq_pkg;

    localparam int ALU_TIMEOUT = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        WAIT_ALU = 3'd4,
        BACK     = 3'd5,
        HALT     = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_ALU    = 3'd1,
        OP_JMP    = 3'd2,
        OP_JZ     = 3'd3,
        OP_JALU   = 3'd4,
        OP_LOOPNZ = 3'd5,
        OP_RSVD   = 3'd6,
        OP_HALT   = 3'd7
    } opcode_t;

    localparam logic [1:0] M_INC  = 2'b00;
    localparam logic [1:0] M_DEC  = 2'b01;
    localparam logic [1:0] M_LOAD = 2'b10;
    localparam logic [1:0] M_ALU  = 2'b11;

    // where EXEC goes next: end of instruction, ALU wait, PC back-step, halt
    typedef enum logic [1:0] {
        NX_END  = 2'd0,
        NX_WAIT = 2'd1,
        NX_BACK = 2'd2,
        NX_HALT = 2'd3
    } next_t;

endpackage

// File: rtl/pc_seq_decode.sv
// pc_seq_decode: opcode and zero flag to EXEC-cycle PC action, ALU launch and successor class
module pc_seq_decode
    import pc_seq_pkg::*;
(
    input  logic [2:0] op,
    input  logic       zflag,
    output logic [1:0] pc_m,
    output logic       pc_en,
    output logic       alu_start,
    output next_t      nxt
);

    // reserved opcode falls through to the NOP defaults
    always_comb begin
        pc_m      = M_INC;
        pc_en     = 1'b0;
        alu_start = 1'b0;
        nxt       = NX_END;
        case (opcode_t'(op))
            OP_ALU: begin
                alu_start = 1'b1;
                nxt       = NX_WAIT;
            end
            OP_JMP: begin
                pc_m  = M_LOAD;
                pc_en = 1'b1;
            end
            OP_JZ: begin
                pc_m  = zflag ? M_LOAD : M_INC;
                pc_en = 1'b1;
            end
            OP_JALU: begin
                pc_m  = M_ALU;
                pc_en = 1'b1;
            end
            OP_LOOPNZ: if (!zflag) begin
                pc_m  = M_DEC;
                pc_en = 1'b1;
                nxt   = NX_BACK;
            end
            OP_HALT: nxt = NX_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute controller driving the PC and ALU of the 8-bit calculator
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic       step_mode,
    input  logic [7:0] instr,
    input  logic       alu_done,
    input  logic       alu_zero,
    output logic [1:0] pc_m,
    output logic       pc_en,
    output logic       alu_start,
    output logic [2:0] alu_op,
    output logic [7:0] ir,
    output logic       zflag,
    output logic [2:0] state,
    output logic       busy,
    output logic       halted,
    output logic       err
);

    localparam int CW = $clog2(ALU_TIMEOUT);

    state_t        st;
    state_t        eoi;
    logic          run_q;
    logic [CW-1:0] cnt;
    logic [1:0]    d_pc_m;
    logic          d_pc_en;
    logic          d_start;
    next_t         d_nx;

    pc_seq_decode u_dec (
        .op        (ir[7:5]),
        .zflag     (zflag),
        .pc_m      (d_pc_m),
        .pc_en     (d_pc_en),
        .alu_start (d_start),
        .nxt       (d_nx)
    );

    assign eoi = step_mode ? IDLE : FETCH;

    // sequencing FSM; the timeout counter only runs inside WAIT_ALU and is cleared on exit
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st    <= IDLE;
            ir    <= 8'h00;
            zflag <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
            run_q <= 1'b0;
        end else begin
            run_q <= run;
            case (st)
                IDLE:     if (run && !run_q) st <= FETCH;
                FETCH: begin
                    ir <= instr;
                    st <= DECODE;
                end
                DECODE:   st <= EXEC;
                EXEC:     st <= d_nx == NX_WAIT ? WAIT_ALU :
                                d_nx == NX_BACK ? BACK :
                                d_nx == NX_HALT ? HALT : eoi;
                WAIT_ALU: if (alu_done) begin
                    zflag <= alu_zero;
                    cnt   <= '0;
                    st    <= eoi;
                end else if (cnt == CW'(ALU_TIMEOUT - 1)) begin
                    err <= 1'b1;
                    cnt <= '0;
                    st  <= HALT;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                BACK:     st <= eoi;
                default:  st <= HALT;
            endcase
        end
    end

    // Moore decode of the registered state; the PC samples these on the falling edge
    always_comb begin
        pc_en     = st == DECODE || st == BACK || (st == EXEC && d_pc_en);
        pc_m      = st == EXEC ? d_pc_m : st == BACK ? M_DEC : M_INC;
        alu_start = st == EXEC && d_start;
        alu_op    = ir[2:0];
        state     = st;
        busy      = st != IDLE && st != HALT;
        halted    = st == HALT;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized instruction-level checking of pc_sequencer against a PC/memory model
module tb_pc_sequencer;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       run = 1'b0;
    logic       step_mode = 1'b1;
    logic [7:0] instr;
    logic       alu_done = 1'b0;
    logic       alu_zero = 1'b0;
    logic [1:0] pc_m;
    logic       pc_en;
    logic       alu_start;
    logic [2:0] alu_op;
    logic [7:0] ir;
    logic       zflag;
    logic [2:0] state;
    logic       busy;
    logic       halted;
    logic       err;

    logic [7:0] mem [256];
    logic [7:0] pc;
    logic [7:0] alu_res = 8'h00;
    logic [7:0] mpc = 8'h00;
    logic       mz = 1'b0;
    bit         in_fetch = 1'b0;
    int         checks = 0;
    int         failures = 0;

    pc_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .run       (run),
        .step_mode (step_mode),
        .instr     (instr),
        .alu_done  (alu_done),
        .alu_zero  (alu_zero),
        .pc_m      (pc_m),
        .pc_en     (pc_en),
        .alu_start (alu_start),
        .alu_op    (alu_op),
        .ir        (ir),
        .zflag     (zflag),
        .state     (state),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    // program counter of the datapath, updated on the falling edge
    always @(negedge clk or posedge clr) begin
        if (clr) pc <= 8'h00;
        else if (pc_en) begin
            case (pc_m)
                2'b00:   pc <= pc + 8'd1;
                2'b01:   pc <= pc - 8'd1;
                2'b10:   pc <= instr;
                default: pc <= alu_res;
            endcase
        end
    end

    assign instr = mem[pc];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill();
        for (int i = 0; i < 256; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 6));
            if ($urandom_range(0, 24) == 0) op = 3'd7;
            mem[i] = {op, 5'($urandom)};
        end
    endtask

    task automatic check_reset();
        chk("rst_state", state, 0);
        chk("rst_ir", ir, 0);
        chk("rst_pc_m", pc_m, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_zflag", zflag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
    endtask

    task automatic do_reset();
        run = 1'b0;
        clr = 1'b1;
        #1;
        check_reset();
        @(posedge clk);
        #1;
        clr = 1'b0;
        mpc = 8'h00;
        mz = 1'b0;
        in_fetch = 1'b0;
        fill();
    endtask

    // one instruction; fd forces the ALU response delay (values above TIMEOUT never answer)
    task automatic exec_one(input bit sm, input int fd);
        logic [7:0] p0, p1, b, exp_pc;
        logic [2:0] op, op_seen, exp_st;
        logic       exp_z, exp_err, exp_halt, zval;
        int         d, exp_cyc, exp_starts, cyc, starts, w;
        p0 = mpc;
        p1 = p0 + 8'd1;
        b = mem[p0];
        op = b[7:5];
        d = fd != 0 ? fd : ($urandom_range(0, 7) == 0 ? 99 : int'($urandom_range(1, 5)));
        zval = 1'($urandom);
        alu_res = 8'($urandom);
        exp_pc = p1;
        exp_cyc = 3;
        exp_z = mz;
        exp_err = 1'b0;
        exp_halt = 1'b0;
        exp_starts = 0;
        case (op)
            3'd1: begin
                exp_starts = 1;
                if (d > TIMEOUT) begin
                    exp_cyc = 3 + TIMEOUT;
                    exp_err = 1'b1;
                    exp_halt = 1'b1;
                end else begin
                    exp_cyc = 3 + d;
                    exp_z = zval;
                end
            end
            3'd2: exp_pc = mem[p1];
            3'd3: exp_pc = mz ? mem[p1] : p0 + 8'd2;
            3'd4: exp_pc = alu_res;
            3'd5: if (!mz) begin
                exp_pc = p0 - 8'd1;
                exp_cyc = 4;
            end
            3'd7: exp_halt = 1'b1;
            default: ;
        endcase
        exp_st = exp_halt ? 3'd6 : sm ? 3'd0 : 3'd1;
        step_mode = sm;
        if (!in_fetch) begin
            run = 1'b1;
            @(posedge clk);
            #1;
            if ($urandom_range(0, 1) == 0) run = 1'b0;
        end
        cyc = 0;
        starts = 0;
        w = 0;
        op_seen = 3'd0;
        do begin
            cyc++;
            if (alu_start) begin
                starts++;
                op_seen = alu_op;
            end
            if (state == 3'd4) w++;
            alu_done = state == 3'd4 ? (w == d) : ($urandom_range(0, 3) == 0);
            alu_zero = state == 3'd4 ? zval : 1'($urandom);
            @(posedge clk);
            #1;
        end while (!(state == 3'd0 || state == 3'd1 || state == 3'd6) && cyc < 60);
        alu_done = 1'b0;
        alu_zero = 1'b0;
        chk("cycles", cyc, exp_cyc);
        chk("end_state", state, exp_st);
        chk("pc", pc, exp_pc);
        chk("ir", ir, b);
        chk("zflag", zflag, exp_z);
        chk("err", err, exp_err);
        chk("halted", halted, exp_halt);
        chk("alu_starts", starts, exp_starts);
        if (exp_starts != 0) chk("alu_op", op_seen, b[2:0]);
        mpc = exp_pc;
        mz = exp_z;
        in_fetch = !exp_halt && !sm;
        run = 1'b0;
        if (exp_st == 3'd0) begin
            @(posedge clk);
            #1;
            chk("idle_hold", state, 0);
        end
        if (exp_halt) begin
            run = 1'b1;
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            chk("halt_ignores_run", state, 6);
            chk("halt_busy", busy, 0);
            run = 1'b0;
            do_reset();
        end
    endtask

    initial begin
        int n;
        fill();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        check_reset();
        @(posedge clk);
        #1;
        check_reset();
        for (int i = 0; i < 400; i++) exec_one($urandom_range(0, 2) != 0, 0);

        do_reset();
        mem[0] = 8'h25;
        exec_one(1'b1, 99);

        do_reset();
        mem[0] = 8'h21;
        step_mode = 1'b1;
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        n = 0;
        while (state != 3'd4 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_reached", state, 4);
        #2;
        clr = 1'b1;
        #1;
        chk("clr_abort_state", state, 0);
        chk("clr_abort_err", err, 0);
        chk("clr_abort_pc_en", pc_en, 0);
        chk("clr_abort_busy", busy, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        alu_done = 1'b1;
        alu_zero = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        alu_done = 1'b0;
        chk("stray_done_state", state, 0);
        chk("stray_done_zflag", zflag, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
